// File: rtl/tdm_audio_unit.sv
// Multi-channel TDM audio serializer: frame FIFO, programmable bit clock,
// frame sync with optional one-bit delay, MSB-first slot data on sdo_out.
module tdm_audio_unit #(
   parameter int CHANNELS   = 4,
   parameter int SAMPLE_W   = 24,
   parameter int SLOT_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_in,
   input  logic [31:0]                  cfg_reg_in,
   input  logic                         play_in,
   input  logic                         tick_in,
   input  logic [CHANNELS*SAMPLE_W-1:0] audio_in,
   output logic                         req_out,
   output logic                         overflow_out,
   output logic                         underrun_out,
   output logic                         fs_out,
   output logic                         sck_out,
   output logic                         sdo_out
);

   localparam int DW  = CHANNELS * SAMPLE_W;
   localparam int FB  = CHANNELS * SLOT_W;
   localparam int BCW = (FB > 1) ? $clog2(FB) : 1;
   localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = AW + 1;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   // Slot k occupies the k-th SLOT_W bits from the top, sample left-justified.
   function automatic logic [FB-1:0] format_frame(input logic [DW-1:0] d);
      logic [FB-1:0] f;
      f = {FB{1'b0}};
      for (int k = 0; k < CHANNELS; k++) begin
         f[FB-1-k*SLOT_W -: SAMPLE_W] = d[k*SAMPLE_W +: SAMPLE_W];
      end
      return f;
   endfunction

   function automatic logic fs_for_bit(input logic [BCW-1:0] b, input logic dly);
      logic v;
      if (dly) begin
         v = (b == BCW'(FB - 1));
      end else begin
         v = (b == BCW'(0));
      end
      return v;
   endfunction

   state_t          r_state;
   state_t          w_state_nxt;
   logic [7:0]      r_div;
   logic            r_delay;
   logic [7:0]      r_div_cnt;
   logic [BCW-1:0]  r_bit_cnt;
   logic            r_lead;
   logic [FB-1:0]   r_shift;
   logic            r_sck;
   logic            r_fs;
   logic            r_sdo;
   logic            r_req;
   logic            r_overflow;
   logic            r_underrun;
   logic [DW-1:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic            w_adv;
   logic            w_last;
   logic            w_entry;
   logic            w_stop;
   logic            w_frame_start;
   logic            w_empty;
   logic            w_full;
   logic            w_pop;
   logic            w_push;
   logic [FB-1:0]   w_frame;
   logic            w_unused_cfg;

   assign w_unused_cfg = ^cfg_reg_in[31:9];
   assign w_empty = (r_count == CW'(0));
   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   // w_adv marks the cycle before an sck falling edge, i.e. the next cycle is a bit boundary.
   assign w_adv   = (r_state == ST_RUN) && (r_div_cnt == r_div) && r_sck;
   assign w_last  = (r_bit_cnt == BCW'(FB - 1)) && !r_lead;
   assign w_pop   = w_frame_start && !w_empty;
   assign w_push  = tick_in && (!w_full || w_pop);
   assign w_frame = format_frame(w_empty ? {DW{1'b0}} : r_mem[r_rd_ptr]);

   // Next-state and frame-boundary decode.
   always_comb begin
      w_state_nxt   = r_state;
      w_entry       = 1'b0;
      w_stop        = 1'b0;
      w_frame_start = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (play_in) begin
               w_state_nxt   = ST_RUN;
               w_entry       = 1'b1;
               w_frame_start = !r_delay;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (w_adv && w_last && !play_in) begin
               w_state_nxt = ST_IDLE;
               w_stop      = 1'b1;
            end else if (w_adv && (r_lead || w_last)) begin
               w_frame_start = 1'b1;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Frame FIFO storage.
   always_ff @(posedge clk) begin
      if (w_push && !w_stop) begin
         r_mem[r_wr_ptr] <= audio_in;
      end
   end

   // FIFO pointers, occupancy and the req/overflow pulses; stopping flushes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= AW'(0);
         r_rd_ptr   <= AW'(0);
         r_count    <= CW'(0);
         r_req      <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_req      <= w_pop;
         r_overflow <= tick_in && w_full && !w_pop;
         if (w_stop) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   // State register, configuration and underrun flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_div      <= 8'd0;
         r_delay    <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && cfg_in) begin
            r_div   <= cfg_reg_in[7:0];
            r_delay <= cfg_reg_in[8];
         end
         if (w_frame_start && w_empty) begin
            r_underrun <= 1'b1;
         end else if (w_stop || (r_state == ST_IDLE && cfg_in)) begin
            r_underrun <= 1'b0;
         end
      end
   end

   // Bit clock divider and serial shifter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt <= 8'd0;
         r_bit_cnt <= BCW'(0);
         r_lead    <= 1'b0;
         r_shift   <= {FB{1'b0}};
         r_sck     <= 1'b0;
         r_fs      <= 1'b0;
         r_sdo     <= 1'b0;
      end else if (w_stop) begin
         r_div_cnt <= 8'd0;
         r_bit_cnt <= BCW'(0);
         r_lead    <= 1'b0;
         r_sck     <= 1'b0;
         r_fs      <= 1'b0;
         r_sdo     <= 1'b0;
      end else if (w_frame_start) begin
         r_div_cnt <= 8'd0;
         r_bit_cnt <= BCW'(0);
         r_lead    <= 1'b0;
         r_sck     <= 1'b0;
         r_sdo     <= w_frame[FB-1];
         r_shift   <= w_frame << 1;
         r_fs      <= fs_for_bit(BCW'(0), r_delay);
      end else if (w_entry) begin
         // Delayed framing: one leading fs bit carrying no data.
         r_div_cnt <= 8'd0;
         r_bit_cnt <= BCW'(0);
         r_lead    <= 1'b1;
         r_sck     <= 1'b0;
         r_fs      <= 1'b1;
         r_sdo     <= 1'b0;
      end else if (w_adv) begin
         r_div_cnt <= 8'd0;
         r_bit_cnt <= r_bit_cnt + BCW'(1);
         r_sck     <= 1'b0;
         r_sdo     <= r_shift[FB-1];
         r_shift   <= r_shift << 1;
         r_fs      <= fs_for_bit(r_bit_cnt + BCW'(1), r_delay);
      end else if (r_state == ST_RUN) begin
         if (r_div_cnt == r_div) begin
            r_div_cnt <= 8'd0;
            r_sck     <= ~r_sck;
         end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
         end
      end else begin
         r_sck <= 1'b0;
         r_fs  <= 1'b0;
         r_sdo <= 1'b0;
      end
   end

   assign req_out      = r_req;
   assign overflow_out = r_overflow;
   assign underrun_out = r_underrun;
   assign fs_out       = r_fs;
   assign sck_out      = r_sck;
   assign sdo_out      = r_sdo;

endmodule

// File: tb/tb_tdm_audio_unit.sv
// Scoreboard bench for tdm_audio_unit: expected (sdo, fs) bits are queued per run
// from a frame-level model; a monitor samples each bit at the sck rising edge.
module tb_tdm_audio_unit;
   localparam int CH = 4;
   localparam int SW = 24;
   localparam int SL = 32;
   localparam int DEPTH = 4;
   localparam int DW = CH * SW;
   localparam int FB = CH * SL;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_in = 1'b0;
   logic [31:0]   cfg_reg_in = 32'd0;
   logic          play_in = 1'b0;
   logic          tick_in = 1'b0;
   logic [DW-1:0] audio_in = '0;
   logic          req_out, overflow_out, underrun_out, fs_out, sck_out, sdo_out;

   tdm_audio_unit #(.CHANNELS(CH), .SAMPLE_W(SW), .SLOT_W(SL), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cfg_in(cfg_in), .cfg_reg_in(cfg_reg_in),
      .play_in(play_in), .tick_in(tick_in), .audio_in(audio_in),
      .req_out(req_out), .overflow_out(overflow_out), .underrun_out(underrun_out),
      .fs_out(fs_out), .sck_out(sck_out), .sdo_out(sdo_out));

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [1:0]    exp_q [$];
   logic [DW-1:0] model_q [$];
   int cur_div = 0;
   int cur_dly = 0;
   int exp_ovf = 0;
   bit mon_en = 1'b0;
   int mon_p = 2;
   int run_id = 0;

   int cyc = 0;
   int req_cnt = 0;
   int ovf_cnt = 0;
   int seen_id = -1;
   int last_rise = 0;
   logic prev_sck = 1'b0;

   function automatic logic exp_bit(input logic [DW-1:0] a, input int b);
      int slot;
      int pos;
      slot = b / SL;
      pos  = b % SL;
      if (pos >= SW) return 1'b0;
      return a[slot*SW + (SW - 1 - pos)];
   endfunction

   always @(negedge clk) begin
      logic [1:0] e;
      cyc = cyc + 1;
      req_cnt = req_cnt + int'(req_out);
      ovf_cnt = ovf_cnt + int'(overflow_out);
      if (mon_en && sck_out && !prev_sck) begin
         if (seen_id != run_id) begin
            seen_id = run_id;
         end else begin
            total++;
            if (cyc - last_rise != mon_p) begin
               bad++;
               $display("FAIL bit_period: got %0d clk, expected %0d", cyc - last_rise, mon_p);
            end
         end
         last_rise = cyc;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_bit: sdo=%0b fs=%0b with no bit expected", sdo_out, fs_out);
         end else begin
            e = exp_q.pop_front();
            if ({sdo_out, fs_out} !== e) begin
               bad++;
               $display("FAIL serial_bit: got sdo=%0b fs=%0b, expected sdo=%0b fs=%0b (%0d left)",
                        sdo_out, fs_out, e[1], e[0], exp_q.size());
            end
         end
      end
      prev_sck = sck_out;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rand_frame();
      logic [DW-1:0] a;
      for (int c = 0; c < CH; c++) a[c*SW +: SW] = SW'($urandom());
      return a;
   endfunction

   task automatic tick_frame(input logic [DW-1:0] a);
      audio_in = a;
      tick_in = 1'b1;
      step();
      tick_in = 1'b0;
      if (model_q.size() < DEPTH) model_q.push_back(a);
      else exp_ovf++;
   endtask

   task automatic do_cfg(input int div, input int dly);
      logic [31:0] r;
      r = $urandom();
      cfg_reg_in = {r[22:0], dly[0], div[7:0]};
      cfg_in = 1'b1;
      step();
      cfg_in = 1'b0;
      cur_div = div;
      cur_dly = dly;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_sck"}, sck_out, 0);
      chk({tag, "_fs"}, fs_out, 0);
      chk({tag, "_sdo"}, sdo_out, 0);
   endtask

   task automatic run(input int npre, input int m, input bit fixed, input bit cfg_run);
      int k, p, d, req0, ovf0, npop;
      logic [DW-1:0] fr;
      logic [31:0] r;
      exp_ovf = 0;
      ovf0 = ovf_cnt;
      for (int i = 0; i < npre; i++) begin
         if (fixed && i == 0) fr = {24'h7FFFFF, 24'h800000, 24'h123456, 24'hA5A5A5};
         else fr = rand_frame();
         tick_frame(fr);
         repeat ($urandom_range(0, 2)) step();
      end
      repeat (3) step();
      chk("overflow_pulses", ovf_cnt - ovf0, exp_ovf);
      k = model_q.size();
      p = 2 * (cur_div + 1);
      if (cur_dly != 0) exp_q.push_back(2'b01);
      for (int j = 0; j < m; j++) begin
         if (model_q.size() != 0) fr = model_q.pop_front();
         else fr = '0;
         for (int b = 0; b < FB; b++)
            exp_q.push_back({exp_bit(fr, b), (cur_dly != 0) ? (b == FB - 1) : (b == 0)});
      end
      npop = (m < k) ? m : k;
      mon_p = p;
      run_id++;
      req0 = req_cnt;
      play_in = 1'b1;
      step();
      d = (cur_dly + (m - 1) * FB + FB / 2) * p;
      if (cfg_run) begin
         repeat (d / 2) step();
         r = $urandom();
         cfg_reg_in = {r[22:0], ~cur_dly[0], 8'(cur_div + 1)};
         cfg_in = 1'b1;
         step();
         cfg_in = 1'b0;
         repeat (d - d / 2 - 1) step();
      end else begin
         repeat (d) step();
      end
      chk("underrun_mid_run", underrun_out, (m > k) ? 1 : 0);
      play_in = 1'b0;
      repeat ((FB / 2) * p + 4) step();
      chk("bits_left_in_scoreboard", exp_q.size(), 0);
      chk_idle_outputs("after_stop");
      chk("underrun_after_stop", underrun_out, 0);
      chk("req_pulses", req_cnt - req0, npop);
      model_q.delete();
   endtask

   task automatic reset_mid_frame();
      do_cfg(1, 0);
      tick_frame(rand_frame());
      tick_frame(rand_frame());
      mon_en = 1'b0;
      play_in = 1'b1;
      step();
      repeat ((2 * SL + SL / 2) * 4) step();
      rst = 1'b1;
      play_in = 1'b0;
      step();
      chk_idle_outputs("rst_mid");
      chk("rst_mid_req", req_out, 0);
      chk("rst_mid_ovf", overflow_out, 0);
      chk("rst_mid_underrun", underrun_out, 0);
      rst = 1'b0;
      model_q.delete();
      cur_div = 0;
      cur_dly = 0;
      repeat (5) step();
      chk_idle_outputs("post_rst_idle");
      mon_en = 1'b1;
      run(1, 1, 1'b0, 1'b0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      chk_idle_outputs("reset");
      chk("reset_req", req_out, 0);
      chk("reset_ovf", overflow_out, 0);
      chk("reset_underrun", underrun_out, 0);
      mon_en = 1'b1;

      run(4, 2, 1'b1, 1'b0);
      do_cfg(3, 1);
      run(2, 2, 1'b0, 1'b0);
      do_cfg($urandom_range(0, 2), $urandom_range(0, 1));
      run(5, 4, 1'b0, 1'b0);
      run(0, 2, 1'b0, 1'b0);
      do_cfg(0, 0);
      chk("underrun_after_cfg", underrun_out, 0);
      do_cfg(1, 0);
      run(3, 3, 1'b0, 1'b1);
      reset_mid_frame();
      for (int t = 0; t < 3; t++) begin
         do_cfg($urandom_range(0, 4), $urandom_range(0, 1));
         run($urandom_range(0, 6), $urandom_range(1, 3), 1'b0, $urandom_range(0, 1) != 0);
      end

      repeat (5) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
